// File: rtl/wide_cmp_pkg.sv
// Shared types and constants for the sequential wide magnitude comparator.
// Holds the FSM state encoding, the one-hot result encoding and a small
// helper that maps the nibble comparator flags onto that encoding.
package wide_cmp_pkg;

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result flags, one-hot while a result is presented, all-zero otherwise.
    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } res_t;

    localparam res_t RES_NONE = 3'b000;
    localparam res_t RES_GT   = 3'b100;
    localparam res_t RES_LT   = 3'b010;
    localparam res_t RES_EQ   = 3'b001;

    // Map a decided (unequal) nibble comparison onto the result encoding.
    function automatic res_t encode_res(input logic gt, input logic lt);
        if (gt)      return RES_GT;
        else if (lt) return RES_LT;
        else         return RES_EQ;
    endfunction

endpackage

// File: rtl/comparator_4bit.sv
// Purely combinational unsigned 4-bit magnitude comparator.
// Time-shared by wide_compare_seq, which feeds it one nibble per cycle.
module comparator_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       gt,
    output logic       lt,
    output logic       eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/wide_compare_seq.sv
// Multi-cycle WIDTH-bit magnitude comparator. Operands are captured on a
// valid/ready accept, then scanned one nibble per cycle from MSB to LSB
// through a single comparator_4bit, stopping at the first unequal nibble.
// The result is held with valid/ready until the consumer takes it.
//
// Build option: define WIDE_CMP_SIGNED_EN to treat the operands as two's
// complement (the sign bit of the top nibble is flipped before comparing).
module wide_compare_seq
    import wide_cmp_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int NIB   = WIDTH / 4,
    localparam int CNT_W = $clog2(NIB + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic [CNT_W-1:0] nib_cnt,
    output logic             busy
);

    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIB - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q;
    res_t             res_q;

    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       cmp_a;
    logic [3:0]       cmp_b;
    logic             cmp_gt;
    logic             cmp_lt;
    logic             cmp_eq;
    logic             last_nib;

    // Select the nibble under examination from the captured operands.
    assign nib_a    = a_q[{idx_q, 2'b00} +: 4];
    assign nib_b    = b_q[{idx_q, 2'b00} +: 4];
    assign last_nib = (idx_q == '0);

`ifdef WIDE_CMP_SIGNED_EN
    // Flipping the sign bit of the top nibble turns a two's complement
    // ordering into an unsigned one; lower nibbles are already unsigned.
    logic msb_nib;
    assign msb_nib = (idx_q == IDX_TOP);
    assign cmp_a   = {nib_a[3] ^ msb_nib, nib_a[2:0]};
    assign cmp_b   = {nib_b[3] ^ msb_nib, nib_b[2:0]};
`else
    assign cmp_a   = nib_a;
    assign cmp_b   = nib_b;
`endif

    comparator_4bit u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .gt (cmp_gt),
        .lt (cmp_lt),
        .eq (cmp_eq)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples pre-edge values regardless of block order.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: accept, scan until a nibble differs or the LSB
    // nibble is done, then hold the result until the consumer takes it.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // state_d unassigned, which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_valid)            state_d = CMP;
            CMP:     if (!cmp_eq || last_nib)    state_d = DONE;
            DONE:    if (res_ready)              state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    // Output logic: handshakes from state, result fields only shown in DONE.
    always_comb begin
        start_ready = (state_q == IDLE);
        res_valid   = (state_q == DONE);
        busy        = (state_q != IDLE);
        gt          = res_valid & res_q.gt;
        lt          = res_valid & res_q.lt;
        eq          = res_valid & res_q.eq;
        nib_cnt     = res_valid ? cnt_q : '0;
    end

    // Datapath: operand capture, nibble index, examined-nibble count, result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the operand registers are datapath-only, but they are
            // cleared here as well so an abandoned compare leaves no residue.
            a_q   <= '0;
            b_q   <= '0;
            idx_q <= '0;
            cnt_q <= '0;
            res_q <= RES_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        a_q   <= a_in;
                        b_q   <= b_in;
                        idx_q <= IDX_TOP;
                        cnt_q <= '0;
                        res_q <= RES_NONE;
                    end
                end
                CMP: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (!cmp_eq)       res_q <= encode_res(cmp_gt, cmp_lt);
                    else if (last_nib) res_q <= RES_EQ;
                    else               idx_q <= idx_q - IDX_W'(1);
                end
                DONE: begin
                    if (res_ready) begin
                        res_q <= RES_NONE;
                        cnt_q <= '0;
                    end
                end
                default: begin
                    res_q <= RES_NONE;
                    cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wide_compare_seq.sv
// Self-checking bench for wide_compare_seq (WIDTH=16). A behavioural model
// derives every expected output from the operands with plain arithmetic;
// a per-cycle compare process checks the DUT against it, and directed
// scenarios pin the model with hand-computed literals.
module tb_wide_compare_seq;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic             gt, lt, eq;
    logic [CNT_W-1:0] nib_cnt;
    logic             busy;

    int total = 0;
    int bad   = 0;

    wide_compare_seq #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .gt          (gt),
        .lt          (lt),
        .eq          (eq),
        .nib_cnt     (nib_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Number of nibbles the scan must look at: up to and including the
    // first differing nibble counted from the MSB, or all of them.
    function automatic int nibs_needed(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        for (int i = NIB - 1; i >= 0; i--) begin
            if (((a >> (4 * i)) & 16'hF) != ((b >> (4 * i)) & 16'hF)) return NIB - i;
        end
        return NIB;
    endfunction

    // {gt, lt, eq} from whole-operand arithmetic comparison.
    function automatic logic [2:0] ref_result(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic g, l;
`ifdef WIDE_CMP_SIGNED_EN
        g = ($signed(a) > $signed(b));
        l = ($signed(a) < $signed(b));
`else
        g = (a > b);
        l = (a < b);
`endif
        return {g, l, (a == b)};
    endfunction

    bit         m_idle = 1'b1;
    int         m_wait = 0;
    logic [2:0] m_res  = 3'b000;
    int         m_k    = 0;
    int         cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model: idle / counting down the nibbles still to examine / holding result.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idle <= 1'b1;
            m_wait <= 0;
            m_res  <= 3'b000;
            m_k    <= 0;
        end else if (m_idle) begin
            if (start_valid) begin
                m_idle <= 1'b0;
                m_k    <= nibs_needed(a_in, b_in);
                m_wait <= nibs_needed(a_in, b_in);
                m_res  <= ref_result(a_in, b_in);
            end
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
        end else if (res_ready) begin
            m_idle <= 1'b1;
        end
    end

    // Compare process: every cycle out of reset, on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            logic       rv;
            logic [8:0] exp_v;
            rv    = !m_idle && (m_wait == 0);
            exp_v = {m_idle, ~m_idle, rv, (rv ? m_res : 3'b000), (rv ? CNT_W'(m_k) : CNT_W'(0))};
            check("cycle {ready,busy,valid,gt,lt,eq,cnt}",
                  {23'd0, start_ready, busy, res_valid, gt, lt, eq, nib_cnt}, {23'd0, exp_v});
        end
    end

    // ---------------- directed helpers ----------------
    // Called at a falling edge; returns at the falling edge of cycle 1.
    task automatic accept_req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string name);
        int n;
        start_valid = 1'b1;
        a_in        = a;
        b_in        = b;
        n = 0;
        while (!start_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check({name, " accept timeout"}, 32'd1, 32'd0);
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    // Called at the falling edge of cycle 1; returns the cycle res_valid is seen.
    task automatic wait_result(input string name, output int lat);
        lat = 1;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!res_valid) check({name, " result timeout"}, 32'd1, 32'd0);
    endtask

    int         lat;
    int         prev_acc;
    int         prev_k;
    logic [2:0] exp_res;
    logic [WIDTH-1:0] ra, rb;

    initial begin
        // Reset state.
        @(negedge clk);
        check("reset outputs {ready,valid,gt,lt,eq,cnt,busy}",
              {23'd0, start_ready, res_valid, gt, lt, eq, nib_cnt, busy}, {23'd0, 9'b1_0000_0000});
        rst = 1'b0;
        @(negedge clk);

        // Equal operands: all four nibbles examined.
        res_ready = 1'b1;
        accept_req(16'h1234, 16'h1234, "eq");
        wait_result("eq", lat);
        check("eq latency", lat, 5);
        check("eq flags", {gt, lt, eq}, 3'b001);
        check("eq nib_cnt", nib_cnt, 4);
        @(negedge clk);
        check("eq start_ready at cycle 6", start_ready, 1);
        @(negedge clk);

        // Decided on the top nibble; sign handling changes the answer.
        accept_req(16'h8000, 16'h7FFF, "msb");
        wait_result("msb", lat);
`ifdef WIDE_CMP_SIGNED_EN
        exp_res = 3'b010;
`else
        exp_res = 3'b100;
`endif
        check("msb latency", lat, 2);
        check("msb flags", {gt, lt, eq}, exp_res);
        check("msb nib_cnt", nib_cnt, 1);
        @(negedge clk);

        // Third nibble decides; operand input changes after accept are ignored.
        accept_req(16'h12A4, 16'h12B4, "mid");
        a_in = 16'hFFFF;
        wait_result("mid", lat);
        check("mid latency", lat, 4);
        check("mid flags", {gt, lt, eq}, 3'b010);
        check("mid nib_cnt", nib_cnt, 3);
        @(negedge clk);

        // Backpressure: result held, a new request waits.
        res_ready = 1'b0;
        accept_req(16'h0005, 16'h0003, "bp");
        wait_result("bp", lat);
        check("bp latency", lat, 5);
        start_valid = 1'b1;
        a_in = 16'h0F00;
        b_in = 16'h0F00;
        for (int i = 0; i < 6; i++) begin
            check("bp held flags", {gt, lt, eq}, 3'b100);
            check("bp held nib_cnt", nib_cnt, 4);
            check("bp held start_ready", start_ready, 0);
            check("bp held res_valid", res_valid, 1);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("bp idle after handshake", {start_ready, busy}, 2'b10);
        @(negedge clk);
        check("bp pending accepted", {start_ready, busy}, 2'b01);
        start_valid = 1'b0;
        wait_result("bp pending", lat);
        check("bp pending latency", lat, 5);
        check("bp pending flags", {gt, lt, eq}, 3'b001);
        @(negedge clk);

        // Reset mid-compare abandons the operation.
        accept_req(16'h1234, 16'h1234, "rst");
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check("rst immediate {ready,valid,gt,lt,eq,cnt,busy}",
                 {23'd0, start_ready, res_valid, gt, lt, eq, nib_cnt, busy}, {23'd0, 9'b1_0000_0000});
        @(negedge clk);
        #1 rst = 1'b0;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (res_valid) lat++;
        end
        check("rst no result afterwards", lat, 0);
        accept_req(16'h0001, 16'h0000, "post-rst");
        wait_result("post-rst", lat);
        check("post-rst latency", lat, 5);
        check("post-rst flags", {gt, lt, eq}, 3'b100);
        check("post-rst nib_cnt", nib_cnt, 4);
        @(negedge clk);

        // Back-to-back with start_valid held: accepts spaced k+2 cycles apart.
        res_ready   = 1'b1;
        start_valid = 1'b1;
        prev_acc    = -1;
        prev_k      = 0;
        for (int i = 0; i < 80; i++) begin
            ra = 16'($urandom);
            rb = ra ^ (16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4))));
            a_in = ra;
            b_in = rb;
            if (start_ready) begin
                if (prev_acc >= 0) check("b2b accept spacing", cyc - prev_acc, prev_k + 2);
                prev_acc = cyc;
                prev_k   = nibs_needed(ra, rb);
            end
            @(negedge clk);
        end

        // Randomized traffic and backpressure against the model.
        for (int i = 0; i < 600; i++) begin
            ra = 16'($urandom);
            rb = ra ^ (16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4))));
            if (start_ready || !start_valid) begin
                start_valid = 1'($urandom_range(0, 1));
                a_in = ra;
                b_in = rb;
            end
            res_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end

        start_valid = 1'b0;
        res_ready   = 1'b1;
        repeat (20) @(negedge clk);
        check("drained to idle", {start_ready, busy, res_valid}, 3'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
